ifu_pipe: RTL and testbench
===========================

Name: ifu_pipe

Overview:
Pipelined, parametrised instruction fetch unit for the MIPS core; successor to the combinational fetch-and-split stage.
- Owns the PC register and drives a synchronous-read instruction memory port (fixed 1-cycle latency).
- Buffers fetched words in a small queue and presents split instruction fields to decode over a valid/ready handshake.
- Supports stall (backpressure) and branch/jump redirect with flush of the queue and of any in-flight fetch.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded at reset.
- QDEPTH, 2, fetch queue entries; legal range 2..8.
- PC_W, 32, PC and instruction-memory address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  PC_W  byte address of the request; always word aligned.
- imem_rdata  in  32  instruction word; valid the cycle after imem_req.
- redirect_valid  in  1  branch/jump taken.
- redirect_pc  in  PC_W  target address; bits [1:0] are ignored (treated as 0).
- out_valid  out  1  queue head is valid.
- out_ready  in  1  decode accepts the head.
- out_pc  out  PC_W  address of the head instruction.
- out_instr  out  32  raw head instruction.
- op  out  6  instr[31:26].
- rs  out  5  instr[25:21].
- rt  out  5  instr[20:16].
- rd  out  5  instr[15:11].
- shamt  out  5  instr[10:6].
- fun  out  6  instr[5:0].
- imm16  out  16  instr[15:0].
- imm26  out  26  instr[25:0].

Behaviour:
- Reset (async, reset_n=0):
  - pc=RESET_PC; queue empty; in-flight flag=0; kill flag=0.
  - out_valid=0; imem_req=0.
  - All field outputs are 0, because they are driven from a zeroed head entry.
- Reset asserted mid-operation: abandons all state immediately; any imem_rdata arriving after release is ignored.
- Issue rule (combinational):
  - pop = out_valid & out_ready.
  - imem_req = reset_n_synced & ~redirect_valid & ((count - pop + inflight) < QDEPTH).
  - imem_addr = pc.
  - On issue: pc <= pc+4, with wrap-around modulo 2^PC_W and no error; inflight <= 1; req_pc <= pc.
- Response: when inflight=1 and kill=0, push {req_pc, imem_rdata} at the end of that cycle.
  - The queue can never overflow because of the issue rule; overflow is an assertion failure.
- Latency:
  - Request in cycle N gives out_valid in cycle N+2.
  - Sustained throughput is 1 instr/cycle with out_ready held high and QDEPTH>=2.
- Output: out_valid = (count != 0). Fields are sliced combinationally from the head entry. Head is stable while out_valid & ~out_ready.
- Simultaneous push and pop: both take effect; count is unchanged.
- Redirect (highest priority, single cycle):
  - Queue flushed (count <= 0). A pop in the same cycle is discarded; decode must not treat it as accepted.
  - If inflight=1, kill <= 1 so the returning word is dropped.
  - pc <= {redirect_pc[PC_W-1:2], 2'b00}.
  - No request issues in the redirect cycle; the first fetch of the target issues in the next cycle.
- Back-to-back redirects: the last one wins; each flushes again.
- Kill clears when the killed response cycle completes.
- There is no explicit state machine. The state is pc, inflight, kill, and queue count/pointers; the pointers wrap modulo QDEPTH.

Decomposition:
- Shared package mips_pkg:
  - Field bit positions: OP_HI/LO, RS_HI/LO, etc.
  - RESET_PC default.
  - Opcode/funct localparams used by decode.
  - Entry width constant ENTRY_W = PC_W+32.
- One sub-module: ifu_fifo.
  - Parametrised synchronous FIFO: WIDTH, DEPTH, push/pop/flush, count, head data.
  - Async active-low reset; flush has priority over push.

Test Plan:
- Reset release, out_ready=1, memory returns addr-derived words → imem_addr sequence 0x3000, 0x3004, 0x3008 on consecutive cycles; first out_valid two cycles after the first request, with out_pc=0x3000; then one instruction per cycle.
- imem_rdata=32'h012A4020 (add $8,$9,$10) at head → op=0, rs=9, rt=10, rd=8, shamt=0, fun=0x20, imm16=0x4020, imm26=0x12A4020.
- Hold out_ready=0 for 5 cycles → count saturates at QDEPTH, imem_req drops, head out_pc is unchanged; on release, order is preserved with no lost or duplicated PCs.
- redirect_valid with redirect_pc=0x3402 while one fetch is in flight and the queue is full → next imem_addr is 0x3400; the killed word never appears; the next out_pc is 0x3400.
- pc=0xFFFF_FFFC issues → next imem_addr is 0x0000_0000.
- Pull reset_n low mid-stream with inflight=1, release after 3 cycles → out_valid=0 immediately; after release, the first fetch is RESET_PC and the stale response is not enqueued.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: instruction field positions, reset vector and the
// opcode/funct encodings that fetch and decode agree on.
package mips_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
   localparam int          PC_W_DEF     = 32;
   localparam int          INSTR_W      = 32;
   localparam int          ENTRY_W      = PC_W_DEF + INSTR_W;

   localparam int OP_HI    = 31;
   localparam int OP_LO    = 26;
   localparam int RS_HI    = 25;
   localparam int RS_LO    = 21;
   localparam int RT_HI    = 20;
   localparam int RT_LO    = 16;
   localparam int RD_HI    = 15;
   localparam int RD_LO    = 11;
   localparam int SHAMT_HI = 10;
   localparam int SHAMT_LO = 6;
   localparam int FUN_HI   = 5;
   localparam int FUN_LO   = 0;
   localparam int IMM16_HI = 15;
   localparam int IMM26_HI = 25;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FUN_JR   = 6'h08;
   localparam logic [5:0] FUN_ADDU = 6'h21;
   localparam logic [5:0] FUN_ADD  = 6'h20;
   localparam logic [5:0] FUN_SUBU = 6'h23;

   function automatic int entryWidth(input int pcW);
      return pcW + INSTR_W;
   endfunction

endpackage

// File: rtl/ifu_pipe_if.sv
// Fetch-unit bus bundle: instruction-memory port, redirect input and the
// decode-side valid/ready head with its split fields.
interface ifu_pipe_if
   import mips_pkg::*;
#(
   parameter int PC_W = 32
);
   logic                 imem_req;
   logic [PC_W-1:0]      imem_addr;
   logic [INSTR_W-1:0]   imem_rdata;
   logic                 redirect_valid;
   logic [PC_W-1:0]      redirect_pc;
   logic                 out_valid;
   logic                 out_ready;
   logic [PC_W-1:0]      out_pc;
   logic [INSTR_W-1:0]   out_instr;
   logic [5:0]           op;
   logic [4:0]           rs;
   logic [4:0]           rt;
   logic [4:0]           rd;
   logic [4:0]           shamt;
   logic [5:0]           fun;
   logic [15:0]          imm16;
   logic [25:0]          imm26;

   modport master (
      output imem_req, imem_addr, out_valid, out_pc, out_instr,
             op, rs, rt, rd, shamt, fun, imm16, imm26,
      input  imem_rdata, redirect_valid, redirect_pc, out_ready
   );

   modport slave (
      input  imem_req, imem_addr, out_valid, out_pc, out_instr,
             op, rs, rt, rd, shamt, fun, imm16, imm26,
      output imem_rdata, redirect_valid, redirect_pc, out_ready
   );

endinterface

// File: rtl/ifu_fifo.sv
// Small synchronous FIFO with flush; flush beats push and pop in the same cycle.
// Pointers wrap modulo DEPTH so non-power-of-two depths work.
module ifu_fifo #(
   parameter  int WIDTH = 64,
   parameter  int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_flush,
   input  logic [WIDTH-1:0] i_data,
   output logic [CNT_W-1:0] o_count,
   output logic [WIDTH-1:0] o_head
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_rdPtr;
   logic [PTR_W-1:0] r_wrPtr;
   logic [CNT_W-1:0] r_count;
   logic             w_doPush;
   logic             w_doPop;

   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign w_doPush = i_push & ~i_flush;
   assign w_doPop  = i_pop & ~i_flush & (r_count != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
            r_wrPtr        <= nextPtr(r_wrPtr);
         end
         if (w_doPop) begin
            r_rdPtr <= nextPtr(r_rdPtr);
         end
         if (w_doPush && !w_doPop) begin
            r_count <= r_count + 1'b1;
         end else if (!w_doPush && w_doPop) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   assign o_count = r_count;
   assign o_head  = r_mem[r_rdPtr];

   // The issue rule upstream guarantees a slot for every response.
   assert property (@(posedge clk) disable iff (!rst_n)
      !(w_doPush && !w_doPop && (r_count == CNT_W'(DEPTH))));

endmodule

// File: rtl/ifu_pipe.sv
// Pipelined MIPS instruction fetch: PC register, 1-cycle synchronous imem port,
// fetch queue toward decode, and redirect with flush of queue and in-flight word.
module ifu_pipe
   import mips_pkg::*;
#(
   parameter int              PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF),
   parameter int              QDEPTH   = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   ifu_pipe_if.master bus
);

   localparam int CNT_W      = $clog2(QDEPTH + 1);
   localparam int LP_ENTRY_W = entryWidth(PC_W);

   logic [PC_W-1:0]       r_pc;
   logic [PC_W-1:0]       r_reqPc;
   logic                  r_inflight;
   logic                  r_kill;
   logic                  r_rstSync;
   logic [CNT_W-1:0]      w_count;
   logic [CNT_W:0]        w_occ;
   logic [LP_ENTRY_W-1:0] w_head;
   logic [INSTR_W-1:0]    w_headInstr;
   logic [PC_W-1:0]       w_redirTarget;
   logic                  w_outValid;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_issue;

   assign w_outValid    = (w_count != '0);
   assign w_pop         = w_outValid & bus.out_ready;
   assign w_push        = r_inflight & ~r_kill;
   assign w_redirTarget = bus.redirect_pc & ~PC_W'(3);

   // Occupancy counts the word already in flight so a response always fits.
   assign w_occ   = (CNT_W+1)'(w_count) + (CNT_W+1)'(r_inflight) - (CNT_W+1)'(w_pop);
   assign w_issue = r_rstSync & ~bus.redirect_valid & (w_occ < (CNT_W+1)'(QDEPTH));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rstSync  <= 1'b0;
         r_pc       <= RESET_PC;
         r_reqPc    <= RESET_PC;
         r_inflight <= 1'b0;
         r_kill     <= 1'b0;
      end else begin
         r_rstSync  <= 1'b1;
         r_inflight <= w_issue;
         if (w_issue) begin
            r_reqPc <= r_pc;
         end
         if (bus.redirect_valid) begin
            r_pc   <= w_redirTarget;
            r_kill <= r_inflight;
         end else begin
            if (w_issue) begin
               r_pc <= r_pc + PC_W'(4);
            end
            r_kill <= 1'b0;
         end
      end
   end

   ifu_fifo #(
      .WIDTH (LP_ENTRY_W),
      .DEPTH (QDEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (reset_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (bus.redirect_valid),
      .i_data  ({r_reqPc, bus.imem_rdata}),
      .o_count (w_count),
      .o_head  (w_head)
   );

   assign w_headInstr   = w_head[INSTR_W-1:0];

   assign bus.imem_req  = w_issue;
   assign bus.imem_addr = r_pc;
   assign bus.out_valid = w_outValid;
   assign bus.out_pc    = w_head[LP_ENTRY_W-1 -: PC_W];
   assign bus.out_instr = w_headInstr;
   assign bus.op        = w_headInstr[OP_HI:OP_LO];
   assign bus.rs        = w_headInstr[RS_HI:RS_LO];
   assign bus.rt        = w_headInstr[RT_HI:RT_LO];
   assign bus.rd        = w_headInstr[RD_HI:RD_LO];
   assign bus.shamt     = w_headInstr[SHAMT_HI:SHAMT_LO];
   assign bus.fun       = w_headInstr[FUN_HI:FUN_LO];
   assign bus.imm16     = w_headInstr[IMM16_HI:0];
   assign bus.imm26     = w_headInstr[IMM26_HI:0];

endmodule

// File: tb/tb_ifu_pipe.sv
// Directed bench for ifu_pipe: a scoreboard queue of expected {pc, instr} is
// drained by a monitor on every accepted head, plus timed checks on the imem port.
module tb_ifu_pipe;
   import mips_pkg::*;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } expT;

   logic clk = 1'b0;
   logic reset_n;
   logic found;
   expT  expQ[$];
   int   nCompared   = 0;
   int   nMismatched = 0;

   always #5 clk = ~clk;

   ifu_pipe_if #(.PC_W(32)) bus();

   ifu_pipe #(
      .PC_W     (32),
      .RESET_PC (32'h0000_3000),
      .QDEPTH   (2)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // Memory contents are a fixed function of the address; 0x3008 holds add $8,$9,$10.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      if (a == 32'h0000_3008) return 32'h012A_4020;
      return a ^ 32'h5A5A_0000;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      nCompared++;
      if (act !== req) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic pushExp(input logic [31:0] pc);
      expT e;
      e.pc    = pc;
      e.instr = memWord(pc);
      expQ.push_back(e);
   endtask

   task automatic applyStimulus(input logic ready, input logic redir, input logic [31:0] rpc);
      @(posedge clk);
      #1;
      bus.out_ready      = ready;
      bus.redirect_valid = redir;
      bus.redirect_pc    = rpc;
   endtask

   task automatic waitReq(input int maxCycles, output logic seen);
      seen = 1'b0;
      for (int i = 0; i < maxCycles && !seen; i++) begin
         @(negedge clk);
         if (bus.imem_req === 1'b1) seen = 1'b1;
      end
      if (!seen) begin
         nCompared++;
         nMismatched++;
         $display("[TB] FAIL wait_req: no imem_req within %0d cycles", maxCycles);
      end
   endtask

   // Synchronous-read memory responder: word appears the cycle after the request.
   initial begin : memModel
      logic        sampReq;
      logic [31:0] sampAddr;
      bus.imem_rdata = '0;
      forever begin
         @(negedge clk);
         sampReq  = bus.imem_req;
         sampAddr = bus.imem_addr;
         @(posedge clk);
         #1;
         if (sampReq === 1'b1) bus.imem_rdata = memWord(sampAddr);
      end
   end

   always @(negedge clk) begin : monitor
      expT e;
      if (reset_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1 &&
          bus.redirect_valid === 1'b0) begin
         if (expQ.size() == 0) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL unexpected_accept: got pc 0x%0h, expected none", bus.out_pc);
         end else begin
            e = expQ.pop_front();
            checkOutput("acc_pc", bus.out_pc, e.pc);
            checkOutput("acc_instr", bus.out_instr, e.instr);
            if (e.pc == 32'h0000_3008) begin
               checkOutput("fld_op", bus.op, 6'd0);
               checkOutput("fld_rs", bus.rs, 5'd9);
               checkOutput("fld_rt", bus.rt, 5'd10);
               checkOutput("fld_rd", bus.rd, 5'd8);
               checkOutput("fld_shamt", bus.shamt, 5'd0);
               checkOutput("fld_fun", bus.fun, 6'h20);
               checkOutput("fld_imm16", bus.imm16, 16'h4020);
               checkOutput("fld_imm26", bus.imm26, 26'h12A4020);
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset_n            = 1'b0;
      bus.out_ready      = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;

      repeat (2) @(negedge clk);
      checkOutput("rst_valid", bus.out_valid, 1'b0);
      checkOutput("rst_req", bus.imem_req, 1'b0);
      checkOutput("rst_pc", bus.out_pc, 32'h0);
      checkOutput("rst_instr", bus.out_instr, 32'h0);
      checkOutput("rst_fields", {bus.op, bus.rs, bus.rt, bus.imm16, bus.imm26}, 64'h0);

      // Streaming from reset with decode always ready.
      for (int i = 0; i < 6; i++) pushExp(32'h3000 + 32'(4 * i));
      @(posedge clk);
      #1;
      reset_n       = 1'b1;
      bus.out_ready = 1'b1;
      waitReq(10, found);
      checkOutput("addr0", bus.imem_addr, 32'h3000);
      checkOutput("lat_valid0", bus.out_valid, 1'b0);
      @(negedge clk);
      checkOutput("addr1", bus.imem_addr, 32'h3004);
      checkOutput("lat_valid1", bus.out_valid, 1'b0);
      @(negedge clk);
      checkOutput("addr2", bus.imem_addr, 32'h3008);
      checkOutput("lat_valid2", bus.out_valid, 1'b1);
      checkOutput("first_pc", bus.out_pc, 32'h3000);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("stream_valid", bus.out_valid, 1'b1);
      end

      // Backpressure: queue fills, requests stop, head holds.
      applyStimulus(1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("stall_head", bus.out_pc, 32'h3018);
         checkOutput("stall_valid", bus.out_valid, 1'b1);
      end
      checkOutput("stall_req", bus.imem_req, 1'b0);

      for (int i = 0; i < 4; i++) pushExp(32'h3018 + 32'(4 * i));
      applyStimulus(1'b1, 1'b0, 32'h0);
      repeat (4) @(negedge clk);

      // Redirect with a word in flight; target has misaligned low bits.
      applyStimulus(1'b0, 1'b1, 32'h3402);
      applyStimulus(1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("redir_req", bus.imem_req, 1'b1);
      checkOutput("redir_addr", bus.imem_addr, 32'h3400);
      @(negedge clk);
      checkOutput("redir_addr1", bus.imem_addr, 32'h3404);
      @(negedge clk);
      checkOutput("redir_valid", bus.out_valid, 1'b1);
      checkOutput("redir_head", bus.out_pc, 32'h3400);
      checkOutput("redir_full_req", bus.imem_req, 1'b0);
      repeat (2) @(negedge clk);
      pushExp(32'h3400);
      pushExp(32'h3404);
      applyStimulus(1'b1, 1'b0, 32'h0);
      repeat (2) @(negedge clk);

      // PC wrap-around at the top of the address space.
      applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF8);
      pushExp(32'hFFFF_FFF8);
      pushExp(32'hFFFF_FFFC);
      pushExp(32'h0000_0000);
      pushExp(32'h0000_0004);
      applyStimulus(1'b1, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("wrap_addr0", bus.imem_addr, 32'hFFFF_FFF8);
      @(negedge clk);
      checkOutput("wrap_addr1", bus.imem_addr, 32'hFFFF_FFFC);
      @(negedge clk);
      checkOutput("wrap_addr2", bus.imem_addr, 32'h0000_0000);
      repeat (3) @(negedge clk);

      // Mid-stream reset while a fetch is in flight.
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      checkOutput("midrst_valid", bus.out_valid, 1'b0);
      checkOutput("midrst_req", bus.imem_req, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      pushExp(32'h3000);
      pushExp(32'h3004);
      pushExp(32'h3008);
      waitReq(10, found);
      checkOutput("refetch_addr", bus.imem_addr, 32'h3000);
      repeat (4) @(negedge clk);
      applyStimulus(1'b0, 1'b0, 32'h0);
      repeat (4) @(negedge clk);
      checkOutput("exp_drained", 64'(expQ.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
